// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and the multiply/divide unit:
// ALUOp values, funct fields, ALU operation codes and the MDU state enum.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  // Immediate-compare forms only look at the low funct nibble.
  localparam logic [3:0] IMM_SUB = 4'b0010;
  localparam logic [3:0] IMM_SLT = 4'b1010;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic is_mdu_funct(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply (shift-add) / restoring divide datapath, one bit per step,
// operating on magnitudes with sign fix-up applied combinationally to the result.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             op_div,
  input  logic             op_sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;   // product high half / partial remainder
  logic [WIDTH-1:0] sh;    // multiplier shifting out / dividend-quotient
  logic [WIDTH-1:0] opnd;  // multiplicand / divisor magnitude
  logic             is_div, neg_q, neg_r, dz;

  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_sub;
  logic [2*WIDTH-1:0] prod, prod_f;

  assign sa    = op_sgn & a[WIDTH-1];
  assign sb    = op_sgn & b[WIDTH-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  assign msum    = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);
  assign shifted = {acc, sh[WIDTH-1]};
  assign ge      = shifted >= {1'b0, opnd};
  // Only used when ge holds, so the true difference is below 2^WIDTH.
  assign rem_sub = shifted[WIDTH-1:0] - opnd;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      sh     <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      acc    <= '0;
      sh     <= mag_a;
      opnd   <= mag_b;
      is_div <= op_div;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      dz     <= op_div & (b == '0);
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        acc <= ge ? rem_sub : shifted[WIDTH-1:0];
        sh  <= {sh[WIDTH-2:0], ge};
      end else begin
        acc <= msum[WIDTH:1];
        sh  <= {msum[0], sh[WIDTH-1:1]};
      end
    end
  end

  assign last   = (cnt == CNT_LAST);
  assign prod   = {acc, sh};
  assign prod_f = neg_q ? -prod : prod;

  always_comb begin
    res_hi = prod_f[2*WIDTH-1:WIDTH];
    res_lo = prod_f[WIDTH-1:0];
    if (is_div) begin
      res_hi = neg_r ? -acc : acc;
      res_lo = dz ? '1 : (neg_q ? -sh : sh);
    end
  end

endmodule

// File: rtl/alu_control_mdu.sv
// ALU operation decode plus multi-cycle MULT/DIV control with HI/LO registers;
// stalls the core from issue through the last iteration, retiring on the FIX edge.
module alu_control_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [OP_W-1:0]  operation,
  output logic             stall,
  output logic [WIDTH-1:0] hilo_rd,
  output logic             hilo_rd_en,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           state, state_nxt;
  logic             rtype, issue, start, step, fix, last;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign rtype = valid & (alu_op == ALUOP_RTYPE);
  assign issue = rtype & is_mdu_funct(funct);

  always_comb begin
    op_code = OP_AND;
    case (alu_op)
      ALUOP_ADD: op_code = OP_ADD;
      ALUOP_SUB: op_code = OP_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          F_ADD:   op_code = OP_ADD;
          F_SUB:   op_code = OP_SUB;
          F_AND:   op_code = OP_AND;
          F_OR:    op_code = OP_OR;
          F_NOR:   op_code = OP_NOR;
          F_SLT:   op_code = OP_SLT;
          default: op_code = OP_AND;
        endcase
      end
      default: begin
        case (funct[3:0])
          IMM_SUB: op_code = OP_SUB;
          IMM_SLT: op_code = OP_SLT;
          default: op_code = OP_AND;
        endcase
      end
    endcase
  end

  assign operation = OP_W'(op_code);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (issue) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    start = (state == ST_IDLE) & issue;
    step  = (state == ST_RUN);
    fix   = (state == ST_FIX);
    stall = start | step;
  end

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .step   (step),
    .op_div (funct[1]),
    .op_sgn (~funct[0]),
    .a      (src_a),
    .b      (src_b),
    .last   (last),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // Moves to HI/LO only take effect while no MDU operation owns the registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (fix) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if ((state == ST_IDLE) && rtype) begin
      if (funct == F_MTHI) hi <= src_a;
      if (funct == F_MTLO) lo <= src_a;
    end
  end

  assign hilo_rd_en = rtype & ((funct == F_MFHI) | (funct == F_MFLO));
  assign hilo_rd    = (funct == F_MFHI) ? hi : lo;

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu: decode table, MDU results and stall length,
// HI/LO moves and reset during an in-flight divide.
module tb_alu_control_mdu;

  logic        clk = 1'b0;
  logic        rst, valid;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b;
  logic [3:0]  operation;
  logic        stall, hilo_rd_en;
  logic [31:0] hilo_rd, hi, lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_control_mdu #(.WIDTH(32), .OP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .alu_op     (alu_op),
    .funct      (funct),
    .src_a      (src_a),
    .src_b      (src_b),
    .operation  (operation),
    .stall      (stall),
    .hilo_rd    (hilo_rd),
    .hilo_rd_en (hilo_rd_en),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue an MDU op, count stalled cycles, then read LO back-to-back after retirement.
  task automatic run_mdu(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
    int n;
    @(posedge clk); #1;
    valid = 1'b1; alu_op = 2'b10; funct = f; src_a = a; src_b = b;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    chk({tag, "_stall_cycles"}, 64'(n), 64'd33);
    @(posedge clk); #1;
    funct = 6'b010010; src_a = 32'hDEAD_BEEF; src_b = 32'hDEAD_BEEF;
    @(negedge clk);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    chk({tag, "_mflo"}, 64'(hilo_rd), 64'(exp_lo));
    chk({tag, "_idle_stall"}, 64'(stall), 64'd0);
  endtask

  logic [1:0] tv_op  [12] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                              2'b11, 2'b11, 2'b10, 2'b11};
  logic [5:0] tv_fn  [12] = '{6'b101010, 6'b100000, 6'b100000, 6'b100010, 6'b100100,
                              6'b100101, 6'b100111, 6'b101010, 6'b110010, 6'b001010,
                              6'b011000, 6'b000000};
  logic [3:0] tv_exp [12] = '{4'b0010, 4'b0110, 4'b0010, 4'b0110, 4'b0000, 4'b0001,
                              4'b1100, 4'b0111, 4'b0110, 4'b0111, 4'b0000, 4'b0000};

  initial begin
    rst = 1'b1; valid = 1'b0; alu_op = 2'b00; funct = 6'd0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      alu_op = tv_op[i]; funct = tv_fn[i];
      @(negedge clk);
      chk($sformatf("decode_%0d", i), 64'(operation), 64'(tv_exp[i]));
      chk($sformatf("decode_%0d_stall", i), 64'(stall), 64'd0);
    end

    // Valid R-type SUB must decode without stalling.
    @(posedge clk); #1;
    valid = 1'b1; alu_op = 2'b10; funct = 6'b100010;
    @(negedge clk);
    chk("sub_op", 64'(operation), 64'h6);
    chk("sub_stall", 64'(stall), 64'd0);
    chk("sub_rd_en", 64'(hilo_rd_en), 64'd0);

    @(posedge clk); #1;
    funct = 6'b010011; src_a = 32'h0000_1234;
    @(negedge clk);
    chk("mtlo_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    funct = 6'b010010; src_a = 32'h0;
    @(negedge clk);
    chk("mflo_rd", 64'(hilo_rd), 64'h1234);
    chk("mflo_rd_en", 64'(hilo_rd_en), 64'd1);

    run_mdu("mult", 6'b011000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_mdu("multu", 6'b011001, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    run_mdu("div", 6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_mdu("divu_zero", 6'b011011, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF);
    run_mdu("div_min", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // MFHI reads the remainder register.
    @(posedge clk); #1;
    funct = 6'b010000;
    @(negedge clk);
    chk("mfhi_rd", 64'(hilo_rd), 64'h0);
    chk("mfhi_rd_en", 64'(hilo_rd_en), 64'd1);

    // Reset during RUN cycle 10 of a divide discards the result.
    @(posedge clk); #1;
    funct = 6'b011010; src_a = 32'd100; src_b = 32'd7;
    repeat (11) @(posedge clk);
    #1;
    chk("pre_rst_stall", 64'(stall), 64'd1);
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_run_stall", 64'(stall), 64'd0);
    chk("rst_run_hi", 64'(hi), 64'd0);
    chk("rst_run_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    valid = 1'b1; alu_op = 2'b10; funct = 6'b010010;
    @(negedge clk);
    chk("rst_mflo_rd", 64'(hilo_rd), 64'd0);
    chk("rst_mflo_rd_en", 64'(hilo_rd_en), 64'd1);
    chk("rst_mflo_stall", 64'(stall), 64'd0);

    // FSM is idle again: MTHI takes effect.
    @(posedge clk); #1;
    funct = 6'b010001; src_a = 32'h0000_ABCD;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("mthi_after_rst", 64'(hi), 64'h0000_ABCD);
    chk("rd_en_invalid", 64'(hilo_rd_en), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
